// File: rtl/mc_control_fsm_pkg.sv
// Shared CPU defines: opcode/funct codes, ALU operations, control FSM states
// and the datapath mux encodings.
package mc_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam int unsigned ALU_OP_LEN = 3;
  localparam logic [ALU_OP_LEN-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_LEN-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_LEN-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_LEN-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_LEN-1:0] ALU_SLT = 3'd4;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

endpackage

// File: rtl/mc_control_fsm_alu_op_decoder.sv
// R-type funct field to ALU operation; funct_valid flags supported codes.
module alu_op_decoder
  import mc_control_fsm_pkg::*;
(
  input  logic [5:0]            funct,
  output logic [ALU_OP_LEN-1:0] alu_op,
  output logic                  funct_valid
);

  always_comb begin
    alu_op      = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control FSM: datapath enables/selects, illegal-instruction
// pulse and retired-instruction counter.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  ir_write,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_source,
  output logic [ALU_OP_LEN-1:0] alu_op,
  output logic                  illegal_inst,
  output logic [CNT_W-1:0]      inst_count,
  output logic [3:0]            state
);

  state_t                state_q, state_d;
  logic                  retire;
  logic [ALU_OP_LEN-1:0] r_alu_op;
  logic                  funct_valid;

  alu_op_decoder u_alu_op_decoder (
    .funct       (funct),
    .alu_op      (r_alu_op),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      inst_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) inst_count <= inst_count + CNT_W'(1);
    end
  end

  assign state = state_q;

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    alu_op        = ALU_ADD;
    illegal_inst  = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXEC_R;
          OP_ADDI:      state_d = EXEC_I;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = WB_MEM;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = funct_valid ? r_alu_op : ALU_ADD;
        state_d   = funct_valid ? WB_R : ILLEGAL;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = WB_I;
      end
      WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      ILLEGAL: begin
        illegal_inst = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset masks every output, including the FETCH decode of the reset state.
    if (!rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = '0;
      pc_source     = '0;
      alu_op        = '0;
      illegal_inst  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle state and packed control checks,
// plus a CNT_W=4 instance fed the same stimulus for counter wrap.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       mem_ready;

  logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_inst;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_op;
  logic [31:0] inst_count;
  logic [3:0]  state;

  logic        w_pcw, w_pwc, w_irw, w_iod, w_mrd, w_mwr, w_m2r, w_rdst, w_rw, w_sa, w_ill;
  logic [1:0]  w_srcb, w_pcs;
  logic [2:0]  w_aluop;
  logic [3:0]  w_count, w_state;

  int checks = 0;
  int errors = 0;

  // Bit layout of ctrl, MSB first.
  localparam logic [17:0] C_PCW  = 18'h20000;
  localparam logic [17:0] C_PWC  = 18'h10000;
  localparam logic [17:0] C_IRW  = 18'h08000;
  localparam logic [17:0] C_IOD  = 18'h04000;
  localparam logic [17:0] C_MRD  = 18'h02000;
  localparam logic [17:0] C_MWR  = 18'h01000;
  localparam logic [17:0] C_M2R  = 18'h00800;
  localparam logic [17:0] C_RDST = 18'h00400;
  localparam logic [17:0] C_RW   = 18'h00200;
  localparam logic [17:0] C_SA   = 18'h00100;
  localparam logic [17:0] B_4    = 18'h00040;
  localparam logic [17:0] B_IMM  = 18'h00080;
  localparam logic [17:0] B_SH   = 18'h000C0;
  localparam logic [17:0] P_OUT  = 18'h00010;
  localparam logic [17:0] P_J    = 18'h00020;
  localparam logic [17:0] OP_SUB = 18'h00002;
  localparam logic [17:0] C_ILL  = 18'h00001;
  localparam logic [17:0] F_RDY  = C_PCW | C_IRW | C_MRD | B_4;
  localparam logic [17:0] D_CTL  = B_SH;

  logic [17:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                 alu_op, illegal_inst};

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal_inst(illegal_inst), .inst_count(inst_count),
    .state(state)
  );

  mc_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(w_pcw), .pc_write_cond(w_pwc), .ir_write(w_irw),
    .i_or_d(w_iod), .mem_read(w_mrd), .mem_write(w_mwr),
    .mem_to_reg(w_m2r), .reg_dst(w_rdst), .reg_write(w_rw),
    .alu_src_a(w_sa), .alu_src_b(w_srcb), .pc_source(w_pcs),
    .alu_op(w_aluop), .illegal_inst(w_ill), .inst_count(w_count),
    .state(w_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle's state and controls, then advance one clock.
  task automatic cyc(input string tag, input int st, input logic [17:0] c);
    #1;
    check({tag, "_state"}, {28'd0, state}, st);
    check({tag, "_ctrl"}, {14'd0, ctrl}, {14'd0, c});
    tick();
  endtask

  logic [5:0]  r_funct [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [17:0] r_op    [4] = '{18'h2, 18'h4, 18'h6, 18'h8};

  initial begin
    rst = 1'b0; opcode = 6'b0; funct = 6'b0; mem_ready = 1'b1;
    tick();
    tick();
    check("rst_state", {28'd0, state}, 0);
    check("rst_ctrl", {14'd0, ctrl}, 0);
    check("rst_count", inst_count, 0);
    rst = 1'b1;

    // add $3,$1,$2
    opcode = 6'b000000; funct = 6'b100000;
    cyc("add_f", 0, F_RDY);
    cyc("add_d", 1, D_CTL);
    cyc("add_x", 6, C_SA);
    cyc("add_wb", 7, C_RDST | C_RW);
    check("add_count", inst_count, 1);

    // lw with two wait states in MEM_RD: 7 cycles
    opcode = 6'b100011;
    cyc("lw_f", 0, F_RDY);
    cyc("lw_d", 1, D_CTL);
    cyc("lw_a", 2, C_SA | B_IMM);
    mem_ready = 1'b0;
    cyc("lw_r0", 3, C_MRD | C_IOD);
    cyc("lw_r1", 3, C_MRD | C_IOD);
    mem_ready = 1'b1;
    cyc("lw_r2", 3, C_MRD | C_IOD);
    cyc("lw_wb", 4, C_M2R | C_RW);
    check("lw_next", {28'd0, state}, 0);
    check("lw_count", inst_count, 2);

    // beq
    opcode = 6'b000100;
    cyc("beq_f", 0, F_RDY);
    cyc("beq_d", 1, D_CTL);
    cyc("beq_x", 10, C_SA | OP_SUB | C_PWC | P_OUT);
    check("beq_next", {28'd0, state}, 0);
    check("beq_count", inst_count, 3);

    // illegal opcode, then R-type with unsupported funct
    opcode = 6'b111111;
    cyc("ilop_f", 0, F_RDY);
    cyc("ilop_d", 1, D_CTL);
    cyc("ilop_x", 12, C_ILL);
    check("ilop_count", inst_count, 3);
    opcode = 6'b000000; funct = 6'b000000;
    cyc("ilfn_f", 0, F_RDY);
    cyc("ilfn_d", 1, D_CTL);
    cyc("ilfn_x", 6, C_SA);
    cyc("ilfn_i", 12, C_ILL);
    check("ilfn_state", {28'd0, state}, 0);
    check("ilfn_count", inst_count, 3);

    // remaining R-type functs
    for (int i = 0; i < 4; i++) begin
      funct = r_funct[i];
      cyc("rt_f", 0, F_RDY);
      cyc("rt_d", 1, D_CTL);
      cyc("rt_x", 6, C_SA | r_op[i]);
      cyc("rt_wb", 7, C_RDST | C_RW);
    end
    check("rt_count", inst_count, 7);

    // addi with a FETCH wait, mem_ready ignored in DECODE/EXEC_I
    opcode = 6'b001000;
    mem_ready = 1'b0;
    cyc("addi_fw", 0, C_MRD | B_4);
    mem_ready = 1'b1;
    cyc("addi_f", 0, F_RDY);
    mem_ready = 1'b0;
    cyc("addi_d", 1, D_CTL);
    cyc("addi_x", 8, C_SA | B_IMM);
    cyc("addi_wb", 9, C_RW);
    check("addi_count", inst_count, 8);
    mem_ready = 1'b1;

    // j
    opcode = 6'b000010;
    cyc("j_f", 0, F_RDY);
    cyc("j_d", 1, D_CTL);
    cyc("j_x", 11, C_PCW | P_J);
    check("j_count", inst_count, 9);

    // sw with one wait state
    opcode = 6'b101011;
    cyc("sw_f", 0, F_RDY);
    cyc("sw_d", 1, D_CTL);
    cyc("sw_a", 2, C_SA | B_IMM);
    mem_ready = 1'b0;
    cyc("sw_w0", 5, C_MWR | C_IOD);
    check("sw_wait_count", inst_count, 9);
    mem_ready = 1'b1;
    cyc("sw_w1", 5, C_MWR | C_IOD);
    check("sw_next", {28'd0, state}, 0);
    check("sw_count", inst_count, 10);

    // sw abandoned by reset during MEM_WR wait
    cyc("sw2_f", 0, F_RDY);
    cyc("sw2_d", 1, D_CTL);
    cyc("sw2_a", 2, C_SA | B_IMM);
    mem_ready = 1'b0;
    cyc("sw2_w", 5, C_MWR | C_IOD);
    rst = 1'b0;
    #1;
    check("sw2_rst_mwr", {31'd0, mem_write}, 0);
    tick();
    check("sw2_rst_state", {28'd0, state}, 0);
    check("sw2_rst_count", inst_count, 0);
    check("sw2_rst_count4", {28'd0, w_count}, 0);
    check("sw2_rst_ctrl", {14'd0, ctrl}, 0);
    rst = 1'b1;
    cyc("post_rst_f", 0, C_MRD | B_4);
    check("post_rst_mwr", {31'd0, mem_write}, 0);

    // 16 jumps: 4-bit counter wraps, 32-bit counter reads 16
    rst = 1'b0;
    tick();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000010;
    for (int n = 1; n <= 16; n++) begin
      cyc("wrap_f", 0, F_RDY);
      cyc("wrap_d", 1, D_CTL);
      cyc("wrap_j", 11, C_PCW | P_J);
      if (n == 15) check("wrap_count4_15", {28'd0, w_count}, 15);
    end
    check("wrap_count4", {28'd0, w_count}, 0);
    check("wrap_state4", {28'd0, w_state}, 0);
    check("wrap_count32", inst_count, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, setting the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous, active-low reset.
REQ-004 The block SHALL have port opcode, input, 6, the IR[31:26] field, held stable from DECODE onward.
REQ-005 The block SHALL have port funct, input, 6, the IR[5:0] field.
REQ-006 The block SHALL have port mem_ready, input, 1, the memory-access completion handshake.
REQ-007 The block SHALL have ports pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write and alu_src_a, each output, 1, as the datapath enables and selects.
REQ-008 The block SHALL have ports alu_src_b and pc_source, output, 2.
- alu_src_b: 00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2.
- pc_source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 The block SHALL have port alu_op, output, ALU_OP_LEN, the ALU operation.
REQ-010 The block SHALL have port illegal_inst, output, 1, a one-cycle pulse on an unsupported instruction.
REQ-011 The block SHALL have port inst_count, output, CNT_W, the number of retired instructions.
REQ-012 The block SHALL have port state, output, 4, the current FSM state for debug.

Function
REQ-013 The block SHALL implement the states FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP and ILLEGAL.
REQ-014 Every control output not listed for a state SHALL be 0 in that state.
REQ-015 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD and pc_source=00.
- ir_write and pc_write SHALL equal mem_ready.
- The block SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=ADD, then branch on opcode:
- 100011 or 101011 go to MEM_ADDR.
- 000000 goes to EXEC_R.
- 001000 goes to EXEC_I.
- 000100 goes to BRANCH.
- 000010 goes to JUMP.
- Any other opcode goes to ILLEGAL.
REQ-017 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and ADD, then go to MEM_RD for lw or MEM_WR for sw.
REQ-018 MEM_RD SHALL drive mem_read=1 and i_or_d=1, holding until mem_ready=1, then go to WB_MEM.
REQ-019 WB_MEM SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=1, then go to FETCH.
REQ-020 MEM_WR SHALL drive mem_write=1 and i_or_d=1, holding until mem_ready=1, then go to FETCH.
REQ-021 EXEC_R SHALL drive alu_src_a=1 and alu_src_b=00, with alu_op decoded from funct.
- 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; these go to WB_R.
- Any other funct goes to ILLEGAL with alu_op=ADD.
REQ-022 WB_R SHALL drive reg_write=1 and reg_dst=1, then go to FETCH.
REQ-023 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10 and ADD, then go to WB_I.
REQ-024 WB_I SHALL drive reg_write=1 and reg_dst=0, then go to FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1 and pc_source=01, then go to FETCH.
REQ-026 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-027 ILLEGAL SHALL drive illegal_inst=1 with no register, memory or PC write, then go to FETCH; the PC stays at the already-incremented value.
REQ-028 inst_count SHALL increment by 1, wrapping modulo 2^CNT_W, on the exit edges of WB_MEM, MEM_WR (when mem_ready=1), WB_R, WB_I, BRANCH and JUMP; it SHALL NOT increment on exit from ILLEGAL.
REQ-029 Latency with zero wait states SHALL be:
- 5 cycles for lw.
- 4 cycles for sw, R-type and addi.
- 3 cycles for beq, j and illegal.
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
REQ-030 State SHALL be registered; outputs SHALL be decoded from state, opcode, funct and mem_ready only, with no combinational path from mem_ready to the next state other than in FETCH, MEM_RD and MEM_WR.
REQ-031 The block SHALL ignore mem_ready in states that do not access memory.

Reset
REQ-032 While rst=0 at a clock edge, the block SHALL set state=FETCH and inst_count=0.
REQ-033 While rst=0, all control outputs and illegal_inst SHALL be forced to 0, overriding FETCH decode.
REQ-034 Reset asserted mid-instruction, including during memory wait, SHALL abandon the instruction with no further writes.
REQ-035 After reset is released, the first active cycle SHALL be FETCH.

Structure
REQ-036 Opcode/funct codes, ALU_OP_LEN with ALU_ADD/SUB/AND/OR/SLT, the state encodings and the alu_src_b/pc_source encodings SHALL live in the shared defines package used by the CPU.
REQ-037 The block SHALL contain one sub-module, alu_op_decoder, mapping funct to alu_op and a funct_valid flag.

Verification
REQ-038 The bench SHALL cover reset, then add $3,$1,$2 with mem_ready=1: states FETCH, DECODE, EXEC_R, WB_R; reg_write=1 and reg_dst=1 in cycle 4; inst_count=1.
REQ-039 The bench SHALL cover lw with mem_ready low for 2 cycles in MEM_RD: 7 cycles total; mem_to_reg=1 and reg_write=1 only in WB_MEM.
REQ-040 The bench SHALL cover beq: pc_write_cond=1, pc_source=01 and alu_op=SUB in cycle 3, and the next state is FETCH.
REQ-041 The bench SHALL cover opcode 111111, then R-type funct 000000: illegal_inst pulses once for each, inst_count is unchanged, and reg_write, mem_write and pc_write stay 0 after FETCH.
REQ-042 The bench SHALL cover rst=0 asserted during a MEM_WR wait: next cycle state=FETCH, inst_count=0 and mem_write=0.
REQ-043 The bench SHALL cover CNT_W=4 with 16 retired j instructions: inst_count wraps to 0.
